// File: rtl/mci_pkg.sv
// Shared opcodes, instruction field positions and FSM/select enums for the
// multi-cycle MIPS-subset sequencer.
package mci_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam int unsigned OP_MSB   = 31;
  localparam int unsigned OP_LSB   = 26;
  localparam int unsigned RS_MSB   = 25;
  localparam int unsigned RS_LSB   = 21;
  localparam int unsigned RT_MSB   = 20;
  localparam int unsigned RT_LSB   = 16;
  localparam int unsigned RD_MSB   = 15;
  localparam int unsigned RD_LSB   = 11;
  localparam int unsigned IMM_MSB  = 15;
  localparam int unsigned IMM_LSB  = 0;
  localparam int unsigned JIDX_MSB = 25;
  localparam int unsigned JIDX_LSB = 0;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExec,
    StBranch,
    StWb,
    StHalt
  } state_e;

  typedef enum logic [1:0] {
    PcSelPlus,
    PcSelBranch,
    PcSelJump
  } pc_sel_e;

endpackage

// File: rtl/mci_next_pc.sv
// Combinational PC arithmetic: sequential increment, branch target, jump
// target and the final next-PC select.
module mci_next_pc
  import mci_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned INST_BYTES = 4
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] base,
  input  logic [15:0]       imm,
  input  logic [25:0]       jidx,
  input  pc_sel_e           sel,
  output logic [ADDR_W-1:0] pc_plus,
  output logic [ADDR_W-1:0] next_pc
);

  logic [ADDR_W-1:0] imm_ext;
  logic [ADDR_W-1:0] branch_tgt;
  logic [ADDR_W-1:0] jump_tgt;

  assign pc_plus    = pc + ADDR_W'(INST_BYTES);
  assign imm_ext    = {{(ADDR_W-16){imm[15]}}, imm};
  assign branch_tgt = base + (imm_ext << 2);

  // The region bits above the 28-bit jump field only exist for ADDR_W > 28.
  if (ADDR_W > 28) begin : g_jump_region
    assign jump_tgt = {base[ADDR_W-1:28], jidx, 2'b00};
  end else begin : g_jump_flat
    assign jump_tgt = {jidx, 2'b00};
  end

  always_comb begin
    next_pc = base;
    unique case (sel)
      PcSelBranch: next_pc = branch_tgt;
      PcSelJump:   next_pc = jump_tgt;
      default:     next_pc = base;
    endcase
  end

endmodule

// File: rtl/mci_seq_ctrl.sv
// Multi-cycle sequencer: owns PC/IR and steps each instruction through
// fetch, decode, execute and branch/writeback, resolving BEQ/BNE/J itself.
module mci_seq_ctrl
  import mci_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DATA_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int unsigned       INST_BYTES = 4,
  parameter int unsigned       CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              im_req,
  output logic [ADDR_W-1:0] im_addr,
  input  logic              im_ack,
  input  logic [DATA_W-1:0] im_rdata,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ir,
  output logic [4:0]        rs_addr,
  output logic [4:0]        rt_addr,
  output logic [4:0]        rd_addr,
  output logic              alu_start,
  input  logic              alu_done,
  input  logic              alu_zero,
  output logic              reg_we,
  output logic              pcsrc,
  output logic              halted,
  output logic              illegal,
  output logic [CNT_W-1:0]  retired
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0] pc_plus_q, pc_plus_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic              halted_q, halted_d;
  logic              illegal_q, illegal_d;
  logic              zero_q, zero_d;
  logic              exec_first_q, exec_first_d;

  logic [5:0]        opcode;
  logic              is_alu_op;
  logic              taken;
  pc_sel_e           pc_sel;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] next_pc;

  assign opcode    = ir_q[OP_MSB:OP_LSB];
  assign is_alu_op = (opcode == OP_RTYPE) || (opcode == OP_BEQ) || (opcode == OP_BNE);
  assign taken     = ((opcode == OP_BEQ) && zero_q) || ((opcode == OP_BNE) && !zero_q);

  // Kept apart from the FSM block so next_pc never feeds back into its own select.
  always_comb begin
    pc_sel = PcSelPlus;
    if (state_q == StExec && opcode == OP_J) begin
      pc_sel = PcSelJump;
    end else if (state_q == StBranch && taken) begin
      pc_sel = PcSelBranch;
    end
  end

  mci_next_pc #(
    .ADDR_W     (ADDR_W),
    .INST_BYTES (INST_BYTES)
  ) u_next_pc (
    .pc      (pc_q),
    .base    (pc_plus_q),
    .imm     (ir_q[IMM_MSB:IMM_LSB]),
    .jidx    (ir_q[JIDX_MSB:JIDX_LSB]),
    .sel     (pc_sel),
    .pc_plus (pc_inc),
    .next_pc (next_pc)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    pc_plus_d    = pc_plus_q;
    retired_d    = retired_q;
    halted_d     = halted_q;
    illegal_d    = illegal_q;
    zero_d       = zero_q;
    exec_first_d = 1'b0;
    im_req       = 1'b0;
    alu_start    = 1'b0;
    reg_we       = 1'b0;
    pcsrc        = 1'b0;

    unique case (state_q)
      StFetch: begin
        im_req = 1'b1;
        if (im_ack) begin
          ir_d      = im_rdata;
          pc_plus_d = pc_inc;
          state_d   = StDecode;
        end
      end
      StDecode: begin
        exec_first_d = 1'b1;
        state_d      = StExec;
      end
      StExec: begin
        if (is_alu_op) begin
          alu_start = exec_first_q;
          if (alu_done) begin
            zero_d  = alu_zero;
            state_d = (opcode == OP_RTYPE) ? StWb : StBranch;
          end
        end else if (opcode == OP_J) begin
          pc_d      = next_pc;
          pcsrc     = 1'b1;
          retired_d = retired_q + CNT_W'(1);
          state_d   = StFetch;
        end else if (opcode == OP_HALT) begin
          halted_d  = 1'b1;
          retired_d = retired_q + CNT_W'(1);
          state_d   = StHalt;
        end else begin
          illegal_d = 1'b1;
          pc_d      = next_pc;
          retired_d = retired_q + CNT_W'(1);
          state_d   = StFetch;
        end
      end
      StBranch: begin
        pcsrc     = taken;
        pc_d      = next_pc;
        retired_d = retired_q + CNT_W'(1);
        state_d   = StFetch;
      end
      StWb: begin
        reg_we    = 1'b1;
        pc_d      = next_pc;
        retired_d = retired_q + CNT_W'(1);
        state_d   = StFetch;
      end
      StHalt: state_d = StHalt;
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StFetch;
      pc_q         <= RESET_PC;
      ir_q         <= '0;
      pc_plus_q    <= '0;
      retired_q    <= '0;
      halted_q     <= 1'b0;
      illegal_q    <= 1'b0;
      zero_q       <= 1'b0;
      exec_first_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      pc_plus_q    <= pc_plus_d;
      retired_q    <= retired_d;
      halted_q     <= halted_d;
      illegal_q    <= illegal_d;
      zero_q       <= zero_d;
      exec_first_q <= exec_first_d;
    end
  end

  assign im_addr = pc_q;
  assign pc      = pc_q;
  assign ir      = ir_q;
  assign rs_addr = ir_q[RS_MSB:RS_LSB];
  assign rt_addr = ir_q[RT_MSB:RT_LSB];
  assign rd_addr = ir_q[RD_MSB:RD_LSB];
  assign halted  = halted_q;
  assign illegal = illegal_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_mci_seq_ctrl.sv
// Directed bench for mci_seq_ctrl: behavioural instruction memory and ALU
// responders with programmable latency, plus hand-computed expectations.
module tb_mci_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        im_req, im_ack = 1'b0;
  logic [31:0] im_addr, im_rdata = '0;
  logic [31:0] pc, ir;
  logic [4:0]  rs_addr, rt_addr, rd_addr;
  logic        alu_start, alu_done = 1'b0, alu_zero = 1'b0;
  logic        reg_we, pcsrc, halted, illegal;
  logic [15:0] retired;

  mci_seq_ctrl u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .im_req    (im_req),
    .im_addr   (im_addr),
    .im_ack    (im_ack),
    .im_rdata  (im_rdata),
    .pc        (pc),
    .ir        (ir),
    .rs_addr   (rs_addr),
    .rt_addr   (rt_addr),
    .rd_addr   (rd_addr),
    .alu_start (alu_start),
    .alu_done  (alu_done),
    .alu_zero  (alu_zero),
    .reg_we    (reg_we),
    .pcsrc     (pcsrc),
    .halted    (halted),
    .illegal   (illegal),
    .retired   (retired)
  );

  // Second instance parked in the 0x1 region, endlessly fed a J instruction.
  logic        im_req_j, im_ack_j, alu_start_j, reg_we_j, pcsrc_j, halted_j, illegal_j;
  logic [31:0] im_addr_j, im_rdata_j, pc_j, ir_j;
  logic [4:0]  rs_j, rt_j, rd_j;
  logic        alu_done_j, alu_zero_j;
  logic [15:0] retired_j;

  mci_seq_ctrl #(
    .RESET_PC (32'h1000_0000)
  ) u_dut_j (
    .clk       (clk),
    .rst_n     (rst_n),
    .im_req    (im_req_j),
    .im_addr   (im_addr_j),
    .im_ack    (im_ack_j),
    .im_rdata  (im_rdata_j),
    .pc        (pc_j),
    .ir        (ir_j),
    .rs_addr   (rs_j),
    .rt_addr   (rt_j),
    .rd_addr   (rd_j),
    .alu_start (alu_start_j),
    .alu_done  (alu_done_j),
    .alu_zero  (alu_zero_j),
    .reg_we    (reg_we_j),
    .pcsrc     (pcsrc_j),
    .halted    (halted_j),
    .illegal   (illegal_j),
    .retired   (retired_j)
  );

  logic [31:0] imem [logic [31:0]];
  int   ack_delay = 0;
  int   alu_delay = 0;
  logic zero_val  = 1'b0;

  int   wait_cnt = 0, alu_cnt = 0;
  bit   alu_pending = 1'b0;
  int   req_cnt = 0, we_cnt = 0, start_cnt = 0, pcsrc_cnt = 0, done_cnt = 0, start_j_cnt = 0;
  logic [4:0] we_addr = '0;

  int   req_base, we_base, start_base, pcsrc_base, done_base;
  int   n_checks = 0, n_fails = 0;

  // Monitors and responders act on the falling edge, so the DUT sees stable inputs.
  always @(negedge clk) begin
    if (im_req) req_cnt++;
    if (reg_we) begin
      we_cnt++;
      we_addr = rd_addr;
    end
    if (alu_start) start_cnt++;
    if (pcsrc) pcsrc_cnt++;
    if (alu_start_j) start_j_cnt++;

    if (!rst_n || !im_req) begin
      im_ack   = 1'b0;
      wait_cnt = 0;
    end else if (wait_cnt >= ack_delay) begin
      im_ack   = 1'b1;
      im_rdata = imem.exists(im_addr) ? imem[im_addr] : 32'h0;
      wait_cnt = 0;
    end else begin
      im_ack = 1'b0;
      wait_cnt++;
    end

    if (alu_start) begin
      alu_pending = 1'b1;
      alu_cnt     = 0;
    end
    if (alu_pending && alu_cnt >= alu_delay) begin
      alu_done    = 1'b1;
      alu_zero    = zero_val;
      alu_pending = 1'b0;
      done_cnt++;
    end else begin
      alu_done = 1'b0;
      if (alu_pending) alu_cnt++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic snapshot();
    req_base   = req_cnt;
    we_base    = we_cnt;
    start_base = start_cnt;
    pcsrc_base = pcsrc_cnt;
    done_base  = done_cnt;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq({tag, "_rst_pc"}, pc, 32'h0);
    check_eq({tag, "_rst_ir"}, ir, 32'h0);
    check_eq({tag, "_rst_retired"}, 32'(retired), 32'h0);
    check_eq({tag, "_rst_flags"}, {28'h0, halted, illegal, reg_we, pcsrc}, 32'h0);
    snapshot();
    rst_n = 1'b1;
  endtask

  task automatic wait_retired(input string tag, input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (int'(retired) == target) break;
    end
    check_eq({tag, "_retired"}, 32'(retired), 32'(target));
  endtask

  initial begin
    im_ack_j   = 1'b1;
    im_rdata_j = 32'h0800_0010;
    alu_done_j = 1'b0;
    alu_zero_j = 1'b0;

    // R-type add $3,$1,$2 with a 2-cycle fetch stall and 1-cycle ALU
    imem.delete();
    imem[32'h0] = 32'h0022_1820;
    ack_delay = 2;
    alu_delay = 1;
    do_reset("rtype");
    wait_retired("rtype", 1, 40);
    check_eq("rtype_req_cycles", 32'(req_cnt - req_base), 32'd3);
    check_eq("rtype_reg_we", 32'(we_cnt - we_base), 32'd1);
    check_eq("rtype_we_addr", 32'(we_addr), 32'd3);
    check_eq("rtype_pc", pc, 32'h4);
    check_eq("rtype_ir", ir, 32'h0022_1820);
    check_eq("rtype_rs_rt", {22'h0, rs_addr, rt_addr}, {22'h0, 5'd1, 5'd2});
    check_eq("rtype_alu_start", 32'(start_cnt - start_base), 32'd1);
    check_eq("rtype_pcsrc", 32'(pcsrc_cnt - pcsrc_base), 32'd0);

    // BEQ imm=2, taken and not taken
    imem.delete();
    imem[32'h0] = 32'h1022_0002;
    ack_delay = 0;
    alu_delay = 0;
    zero_val  = 1'b1;
    do_reset("beq_t");
    wait_retired("beq_t", 1, 40);
    check_eq("beq_t_pc", pc, 32'd12);
    check_eq("beq_t_pcsrc", 32'(pcsrc_cnt - pcsrc_base), 32'd1);
    check_eq("beq_t_reg_we", 32'(we_cnt - we_base), 32'd0);

    zero_val = 1'b0;
    do_reset("beq_nt");
    wait_retired("beq_nt", 1, 40);
    check_eq("beq_nt_pc", pc, 32'd4);
    check_eq("beq_nt_pcsrc", 32'(pcsrc_cnt - pcsrc_base), 32'd0);

    // Two R-types, then BNE imm=-1 at pc=8 jumps back onto itself
    imem.delete();
    imem[32'h8] = 32'h1422_FFFF;
    zero_val = 1'b0;
    do_reset("bne");
    wait_retired("bne", 3, 100);
    check_eq("bne_pc", pc, 32'd8);
    check_eq("bne_pcsrc", 32'(pcsrc_cnt - pcsrc_base), 32'd1);
    check_eq("bne_reg_we", 32'(we_cnt - we_base), 32'd2);

    // J at pc=0 to word index 0x10
    imem.delete();
    imem[32'h0] = 32'h0800_0010;
    do_reset("jump");
    wait_retired("jump", 1, 40);
    check_eq("jump_pc", pc, 32'h40);
    check_eq("jump_alu_start", 32'(start_cnt - start_base), 32'd0);
    check_eq("jump_pcsrc", 32'(pcsrc_cnt - pcsrc_base), 32'd1);

    // HALT is absorbing
    imem.delete();
    imem[32'h0] = 32'hFC00_0000;
    do_reset("halt");
    for (int i = 0; i < 40 && !halted; i++) begin
      @(posedge clk);
      #1;
    end
    check_eq("halt_set", 32'(halted), 32'd1);
    check_eq("halt_retired", 32'(retired), 32'd1);
    snapshot();
    repeat (20) @(posedge clk);
    #1;
    check_eq("halt_no_req", 32'(req_cnt - req_base), 32'd0);
    check_eq("halt_sticky", 32'(halted), 32'd1);
    check_eq("halt_pc", pc, 32'h0);

    // Unknown opcode 0x2A: flagged, then execution carries on at pc+4
    imem.delete();
    imem[32'h0] = 32'hA800_0000;
    do_reset("illegal");
    wait_retired("illegal", 1, 40);
    check_eq("illegal_set", 32'(illegal), 32'd1);
    check_eq("illegal_pc", pc, 32'h4);
    check_eq("illegal_not_halted", 32'(halted), 32'd0);
    wait_retired("illegal_next", 2, 40);
    check_eq("illegal_next_pc", pc, 32'h8);
    check_eq("illegal_sticky", 32'(illegal), 32'd1);

    // Reset while waiting on alu_done; the late done must be ignored
    imem.delete();
    alu_delay = 6;
    do_reset("late");
    for (int i = 0; i < 30 && (start_cnt - start_base) == 0; i++) begin
      @(posedge clk);
      #1;
    end
    check_eq("late_launched", 32'(start_cnt - start_base), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("late_rst_pc", pc, 32'h0);
    check_eq("late_rst_retired", 32'(retired), 32'd0);
    ack_delay = 40;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_eq("late_done_seen", 32'(done_cnt - done_base), 32'd1);
    check_eq("late_no_reg_we", 32'(we_cnt - we_base), 32'd0);
    check_eq("late_retired", 32'(retired), 32'd0);
    check_eq("late_pc", pc, 32'h0);
    check_eq("late_in_fetch", 32'(im_req), 32'd1);
    check_eq("late_no_relaunch", 32'(start_cnt - start_base), 32'd1);

    // Region-preserving jump from 0x1000_0000
    check_eq("jreg_pc", pc_j, 32'h1000_0040);
    check_eq("jreg_alu_start", 32'(start_j_cnt), 32'd0);
    check_eq("jreg_retired_nz", {31'h0, retired_j != 16'h0}, 32'd1);
    check_eq("jreg_flags", {30'h0, halted_j, illegal_j}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/mci_seq_ctrl.md
Name: mci_seq_ctrl

Overview:
- Parametrised multi-cycle sequencer for the single-issue MIPS-subset core.
- Owns the PC and instruction register, and steps each instruction through fetch, decode, execute, branch/writeback.
- Talks to instruction memory over a req/ack handshake and to the register-file/ALU datapath over a start/done handshake.
- Resolves BEQ, BNE and J in hardware, so benches no longer sequence the PC by hand.

Parameters:
- ADDR_W, 32: PC / instruction-memory address width; legal range 28..32.
- DATA_W, 32: instruction width; fixed field layout requires 32.
- RESET_PC, 0: PC value loaded on reset.
- INST_BYTES, 4: PC increment per instruction.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  single core clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- im_req  out  1  instruction fetch request.
- im_addr  out  ADDR_W  fetch address; equals pc.
- im_ack  in  1  fetch data valid this cycle.
- im_rdata  in  DATA_W  fetched instruction.
- pc  out  ADDR_W  current PC.
- ir  out  DATA_W  instruction register.
- rs_addr  out  5  ir[25:21].
- rt_addr  out  5  ir[20:16].
- rd_addr  out  5  ir[15:11].
- alu_start  out  1  one-cycle ALU launch pulse.
- alu_done  in  1  ALU result and alu_zero valid.
- alu_zero  in  1  ALU result == 0.
- reg_we  out  1  one-cycle register write strobe to rd_addr.
- pcsrc  out  1  one-cycle pulse marking a taken branch or jump.
- halted  out  1  HALT executed; sticky.
- illegal  out  1  unknown opcode seen; sticky.
- retired  out  CNT_W  count of completed instructions; wraps modulo 2^CNT_W.

Behaviour:
- Reset (asynchronous): state=FETCH, pc=RESET_PC, ir=0, pc_plus=0, retired=0. All strobes, halted and illegal are 0.
- FETCH:
  - im_req=1 with im_addr=pc, held stable until im_ack.
  - On im_ack: ir<=im_rdata, pc_plus<=pc+INST_BYTES (wraps modulo 2^ADDR_W), next state DECODE.
  - im_ack arriving in the same cycle im_req rises is legal, giving a 1-cycle fetch.
- DECODE: exactly 1 cycle. rs_addr/rt_addr/rd_addr are driven combinationally from ir at all times.
- EXEC, by opcode ir[31:26]:
  - R (000000), BEQ (000100), BNE (000101): alu_start=1 for the first EXEC cycle only, then wait in EXEC for alu_done. On alu_done: R goes to WB; BEQ/BNE go to BRANCH.
  - J (000010): no ALU launch. pc<={pc_plus[ADDR_W-1:28], ir[25:0], 2'b00}, pcsrc=1, retired++, next FETCH.
  - HALT (111111): halted<=1, retired++, next HALT.
  - Any other opcode: illegal<=1, pc<=pc_plus, retired++, next FETCH.
  - alu_done arriving in the same cycle as alu_start is accepted.
- BRANCH: 1 cycle.
  - taken=(BEQ & alu_zero)|(BNE & ~alu_zero), using alu_zero sampled with alu_done (registered).
  - Taken: pc<=pc_plus+(sign_extend(ir[15:0])<<2), pcsrc=1. Not taken: pc<=pc_plus.
  - retired++, next FETCH.
- WB: 1 cycle. reg_we=1, pc<=pc_plus, retired++, next FETCH.
- HALT: absorbing. No requests or strobes until rst_n is asserted.
- Latency: R = fetch+3 cycles with 1-cycle ALU; BEQ/BNE = fetch+3; J = fetch+2.
- Reset mid-operation: an outstanding im_req or alu_start is abandoned. Late im_ack/alu_done after reset are ignored unless the FSM is in the matching wait state.
- Spurious im_ack outside FETCH and spurious alu_done outside EXEC: ignored.
- Offset arithmetic is done at ADDR_W width. Branch targets wrap modulo 2^ADDR_W.

Decomposition:
- Package mci_pkg holds:
  - opcode constants OP_RTYPE, OP_BEQ, OP_BNE, OP_J, OP_HALT;
  - state enum FETCH/DECODE/EXEC/BRANCH/WB/HALT;
  - instruction field index constants.
- One sub-module, mci_next_pc: combinational target computation (pc_plus, branch target, jump target, select). It is reused later by a pipelined fetch unit.

Test Plan:
- Reset then fetch at pc=0 with im_ack after 2 cycles, R-type add, alu_done after 1 cycle -> im_req held 3 cycles; reg_we pulses once with rd_addr=ir[15:11]; pc=4; retired=1.
- BEQ with imm=2 at pc=0, alu_zero=1 -> pcsrc pulses; pc=12. Same with alu_zero=0 -> pc=4, pcsrc stays 0.
- BNE with imm=0xFFFF at pc=8, alu_zero=0 -> pc=8 (pc_plus 12 minus 4), branch taken.
- J with ir[25:0]=0x10 at pc=0x1000_0000 -> pc=0x1000_0040; alu_start never asserted.
- Opcode 0x3F -> halted=1; im_req low for 20 following cycles. Opcode 0x2A -> illegal=1 and execution continues at pc+4.
- rst_n dropped while waiting on alu_done, then a late alu_done -> pc=RESET_PC, state FETCH, no reg_we, retired=0.
